fetch_stage: RTL and testbench

- Instruction-fetch stage that feeds the decode stage: holds the fetch PC, issues word reads on the instruction bus, and buffers one fetched instruction with its PC.
- Hands {instr, pc} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from decode and preserves MIPS branch-delay-slot semantics: the instruction after a branch is always delivered before the target.

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding bus read, one-entry output buffer,
// and redirect handling that always delivers the branch delay slot first.
//
//   state  | meaning
//   IDLE   | no request outstanding; requests when the buffer is empty or draining
//   ADDR   | request raised, holding ireq_addr until the bus accepts it
//   DATA   | address accepted, waiting for read data
module fetch_stage #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ireq_valid,
  output logic [ADDR_W-1:0] ireq_addr,
  input  logic              ireq_addr_ok,
  input  logic              iresp_data_ok,
  input  logic [31:0]       iresp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;

  logic              issue, load, consume, redir, case_a, case_b;
  logic [ADDR_W-1:0] tgt, slot_pc, past_slot_pc;

  assign ireq_valid = !reset && ((state_q == S_ADDR) ||
                      (state_q == S_IDLE && (!out_valid_q || out_ready)));
  assign ireq_addr  = fetch_pc_q & WORD_MASK;

  assign issue        = ireq_valid && ireq_addr_ok;
  assign load         = iresp_data_ok && (issue || state_q == S_DATA);
  assign consume      = out_valid_q && out_ready;
  assign redir        = consume && redirect_valid;
  assign tgt          = redirect_target & WORD_MASK;
  assign slot_pc      = out_pc_q + ADDR_W'(4);
  assign past_slot_pc = out_pc_q + ADDR_W'(8);
  // Delay slot already gone out (A) or going out right now (B); otherwise defer.
  assign case_a       = redir && !issue && (fetch_pc_q == past_slot_pc);
  assign case_b       = redir && issue && (fetch_pc_q == slot_pc);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    if (issue) begin
      issued_pc_d = ireq_addr;
      if (pend_q) begin
        fetch_pc_d = pend_tgt_q;
        pend_d     = 1'b0;
      end else if (case_b) begin
        fetch_pc_d = tgt;
      end else begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
    end else if (case_a) begin
      fetch_pc_d = tgt;
    end

    if (redir && !case_a && !case_b) begin
      pend_d     = 1'b1;
      pend_tgt_d = tgt;
    end

    if (consume) out_valid_d = 1'b0;
    if (load) begin
      out_valid_d = 1'b1;
      out_instr_d = iresp_data;
      out_pc_d    = (state_q == S_DATA) ? issued_pc_q : ireq_addr;
    end

    case (state_q)
      S_IDLE, S_ADDR: begin
        if (ireq_valid) begin
          if (!ireq_addr_ok)      state_d = S_ADDR;
          else if (iresp_data_ok) state_d = S_IDLE;
          else                    state_d = S_DATA;
        end
      end
      S_DATA:  if (iresp_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: randomized bus/decode behaviour against a program-order
// model with a one-entry scoreboard, plus directed delay-slot and reset scenarios.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk, reset;
  logic        ireq_valid, ireq_addr_ok, iresp_data_ok;
  logic [31:0] ireq_addr, iresp_data;
  logic        out_valid, out_ready, redirect_valid;
  logic [31:0] out_instr, out_pc, redirect_target;

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_addr_ok(ireq_addr_ok),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;

  int checks = 0, failures = 0;

  int          p_rdy, p_aok, p_dok, p_br;
  logic        br_force, stall_en;
  logic [31:0] br_pc, br_tgt, stall_pc;

  // Model: bus outstanding flag, output buffer contents, and program order.
  logic        outst;
  logic [31:0] outst_addr;
  ent_t        sb[$];
  logic [31:0] exp_pc, tgt_hold;
  logic        tgt_pend;
  logic        hold_prev;
  logic [31:0] hold_addr;
  logic [31:0] iss_log[$], del_log[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endfunction

  always @(negedge clk) begin
    logic hs, resp, cons;
    ent_t e;
    logic [31:0] rpc;
    if (reset) begin
      outst = 1'b0; sb.delete(); exp_pc = RST_PC; tgt_pend = 1'b0; hold_prev = 1'b0;
      iss_log.delete(); del_log.delete();
    end else begin
      if (hold_prev) begin
        chk("addr_hold_valid", ireq_valid, 1);
        chk("addr_hold_addr", ireq_addr, hold_addr);
      end
      if (ireq_valid) chk("addr_align", ireq_addr & 32'd3, 0);
      if (outst) chk("single_outstanding", ireq_valid, 0);
      chk("out_valid", out_valid, sb.size() != 0);
      if (sb.size() != 0) begin
        chk("out_pc", out_pc, sb[0].pc);
        chk("out_instr", out_instr, sb[0].instr);
      end
      hs   = ireq_valid & ireq_addr_ok;
      resp = outst ? iresp_data_ok : (hs & iresp_data_ok);
      cons = (sb.size() != 0) & out_ready;
      hold_prev = ireq_valid & !ireq_addr_ok;
      hold_addr = ireq_addr;
      if (hs) iss_log.push_back(ireq_addr);
      if (cons) begin
        e = sb.pop_front();
        chk("pc_order", e.pc, exp_pc);
        del_log.push_back(e.pc);
        if (redirect_valid) begin
          tgt_pend = 1'b1; tgt_hold = redirect_target & ~32'd3; exp_pc = e.pc + 32'd4;
        end else if (tgt_pend) begin
          exp_pc = tgt_hold; tgt_pend = 1'b0;
        end else begin
          exp_pc = e.pc + 32'd4;
        end
      end
      if (resp) begin
        rpc = outst ? outst_addr : ireq_addr;
        e.pc = rpc; e.instr = mem(rpc);
        sb.push_back(e);
        outst = 1'b0;
        chk("buffer_depth", sb.size(), 1);
      end else if (hs) begin
        outst = 1'b1; outst_addr = ireq_addr;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    out_ready    = ($urandom_range(99) < p_rdy);
    ireq_addr_ok = ($urandom_range(99) < p_aok);
    if (stall_en && out_valid && out_pc == stall_pc) ireq_addr_ok = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = $urandom;
    if (out_valid && out_ready && !tgt_pend) begin
      if (br_force) begin
        if (out_pc == br_pc) begin redirect_valid = 1'b1; redirect_target = br_tgt; end
      end else if ($urandom_range(99) < p_br) begin
        redirect_valid = 1'b1;
      end
    end
    iresp_data_ok = outst ? ($urandom_range(99) < p_dok)
                          : (ireq_addr_ok && ($urandom_range(99) < p_dok));
    #1 iresp_data = mem(outst ? outst_addr : ireq_addr);
  endtask

  task automatic do_reset(input logic late_dok);
    @(posedge clk); #1;
    reset = 1'b1; redirect_valid = 1'b0; ireq_addr_ok = 1'b0; iresp_data_ok = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ireq_valid", ireq_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_ireq_addr", ireq_addr, RST_PC);
    reset = 1'b0;
    iresp_data_ok = late_dok;
  endtask

  task automatic set_knobs(input int rdy, input int aok, input int dok);
    p_rdy = rdy; p_aok = aok; p_dok = dok;
  endtask

  initial begin
    int n0;
    int idx;
    logic [31:0] lits[4];
    reset = 1'b0; out_ready = 1'b0; ireq_addr_ok = 1'b0; iresp_data_ok = 1'b0;
    iresp_data = '0; redirect_valid = 1'b0; redirect_target = '0;
    p_br = 0; br_force = 1'b0; stall_en = 1'b0; br_pc = '0; br_tgt = '0; stall_pc = '0;
    outst = 1'b0; tgt_pend = 1'b0; hold_prev = 1'b0; exp_pc = RST_PC;
    set_knobs(100, 100, 100);
    #1 reset = 1'b1;

    // Zero-wait streaming from reset
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (i >= 1) chk("stream_valid", out_valid, 1);
    end
    for (int i = 0; i < 3; i++) begin
      chk("stream_iss", iss_log[i], RST_PC + 32'(4 * i));
      chk("stream_del", del_log[i], RST_PC + 32'(4 * i));
    end

    // Decode stall for 5 cycles, then resume
    n0 = iss_log.size();
    set_knobs(0, 100, 100);
    repeat (5) step();
    chk("stall_issues", (iss_log.size() - n0) <= 1, 1);
    set_knobs(100, 100, 100);
    repeat (10) step();

    // Slow bus: addr_ok after 3 cycles, data_ok 2 cycles after that
    set_knobs(100, 0, 0);
    repeat (3) step();
    set_knobs(100, 100, 0);
    step();
    set_knobs(100, 0, 0);
    step();
    set_knobs(100, 0, 100);
    step();
    chk("slow_issue_addr", iss_log[iss_log.size() - 1], RST_PC + 32'(4 * (iss_log.size() - 1)));
    set_knobs(100, 100, 100);
    repeat (4) step();
    for (int i = 0; i < del_log.size(); i++)
      chk("linear_seq", del_log[i], RST_PC + 32'(4 * i));

    // Branch at BFC00010, delay slot issuing in the consume cycle
    lits[0] = 32'hBFC0_0010; lits[1] = 32'hBFC0_0014; lits[2] = 32'hBFC0_0100; lits[3] = 32'hBFC0_0104;
    do_reset(1'b0);
    br_force = 1'b1; br_pc = 32'hBFC0_0010; br_tgt = 32'hBFC0_0101;
    repeat (14) step();
    for (int i = 0; i < 4; i++) begin
      chk("caseB_del", del_log[4 + i], lits[i]);
      chk("caseB_iss", iss_log[4 + i], lits[i]);
    end

    // Same branch, delay slot not yet issued when the branch is consumed
    do_reset(1'b0);
    stall_en = 1'b1; stall_pc = 32'hBFC0_0010;
    set_knobs(100, 100, 50);
    repeat (60) step();
    idx = -1;
    for (int i = 0; i < iss_log.size(); i++)
      if (idx < 0 && iss_log[i] == 32'hBFC0_0010) idx = i;
    chk("caseC_found", idx, 4);
    for (int i = 0; i < 4; i++) begin
      chk("caseC_iss", iss_log[4 + i], lits[i]);
      chk("caseC_del", del_log[4 + i], lits[i]);
    end
    br_force = 1'b0; stall_en = 1'b0;

    // Reset while waiting for data, stale data_ok right after release
    do_reset(1'b0);
    set_knobs(100, 100, 0);
    for (int i = 0; i < 20 && !outst; i++) step();
    chk("reach_data", outst, 1);
    do_reset(1'b1);
    @(negedge clk); #1;
    chk("late_dok_ignored", out_valid, 0);
    set_knobs(100, 100, 100);
    repeat (6) step();
    chk("post_rst_iss", iss_log[0], RST_PC);
    chk("post_rst_del", del_log[0], RST_PC);

    // Randomized traffic with random branches
    do_reset(1'b0);
    p_br = 15;
    for (int blk = 0; blk < 15; blk++) begin
      set_knobs($urandom_range(100, 20), $urandom_range(100, 20), $urandom_range(100, 20));
      repeat (200) step();
    end
    chk("progress", del_log.size() > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
